// File: rtl/prs_pkg.sv
// Shared constants and state enumeration for the program loader.
package prs_pkg;
  localparam int PRS_MEM_DEPTH = 16;
  localparam int PRS_ADDR_W    = 4;
  localparam int PRS_CNT_W     = PRS_ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_FILL,
    ST_RUN,
    ST_ERR
  } prs_state_e;
endpackage

// File: rtl/prs_prog_loader.sv
// Byte-stream program loader for a 16-byte CPU RAM: length, data, optional XOR
// checksum (PRS_LOADER_CHECKSUM_EN), zero fill of the tail, then CPU release.
module prs_prog_loader
  import prs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_req,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [PRS_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_run,
  output logic                  done,
  output logic                  err
);
  localparam logic [PRS_CNT_W-1:0] CNT_FULL = PRS_CNT_W'(PRS_MEM_DEPTH);
  localparam logic [PRS_CNT_W-1:0] CNT_LAST = PRS_CNT_W'(PRS_MEM_DEPTH - 1);

  prs_state_e            state_q, state_d;
  logic [PRS_CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRS_CNT_W-1:0]  len_q, len_d;
`ifdef PRS_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif
  logic                  byte_ready_q, byte_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [PRS_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  cpu_run_q, cpu_run_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept;

  assign accept = byte_valid & byte_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
`ifdef PRS_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_run_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
`ifdef PRS_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_run_q    <= cpu_run_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
`ifdef PRS_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // A restart overrides everything, including a byte accepted this cycle.
    if (load_req) begin
      state_d = ST_LEN;
    end else begin
      case (state_q)
        ST_LEN: begin
          if (accept) begin
            if (byte_in == 8'd0 || byte_in > 8'(PRS_MEM_DEPTH)) begin
              state_d = ST_ERR;
            end else begin
              len_d   = byte_in[PRS_CNT_W-1:0];
              cnt_d   = '0;
`ifdef PRS_LOADER_CHECKSUM_EN
              csum_d  = '0;
`endif
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q[PRS_ADDR_W-1:0];
            mem_wdata_d = byte_in;
            cnt_d       = cnt_q + 1'b1;
`ifdef PRS_LOADER_CHECKSUM_EN
            csum_d      = csum_q ^ byte_in;
            if (cnt_d == len_q) state_d = ST_CHK;
`else
            if (cnt_d == len_q) state_d = (cnt_d == CNT_FULL) ? ST_RUN : ST_FILL;
`endif
          end
        end
`ifdef PRS_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (accept) begin
            if (byte_in != csum_q) state_d = ST_ERR;
            else                   state_d = (cnt_q == CNT_FULL) ? ST_RUN : ST_FILL;
          end
        end
`endif
        ST_FILL: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[PRS_ADDR_W-1:0];
          mem_wdata_d = 8'h00;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = ST_RUN;
        end
        ST_IDLE, ST_RUN, ST_ERR: ;
        default: state_d = ST_IDLE;
      endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    byte_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
    cpu_run_d    = (state_d == ST_RUN);
    done_d       = (state_d == ST_RUN);
    err_d        = (state_d == ST_ERR);
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_prs_prog_loader.sv
// Directed bench for prs_prog_loader: transaction-level reference model checked
// every cycle, plus literal end-of-scenario expectations on the captured RAM image.
module tb_prs_prog_loader;
`ifdef PRS_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_LEN = 1, M_DATA = 2, M_CHK = 3, M_FILL = 4, M_RUN = 5, M_ERR = 6;

  logic       clk = 1'b0;
  logic       rst_n, load_req, byte_valid;
  logic [7:0] byte_in;
  logic       byte_ready, mem_we, cpu_run, done, err;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;

  prs_prog_loader dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_run(cpu_run),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the loader must present after each clock edge.
  int         stage;
  int         m_len, m_idx;
  logic [7:0] m_x;
  int         fill_q[$];
  logic       exp_ready, exp_we, exp_run, exp_done, exp_err;
  logic [3:0] exp_addr;
  logic [7:0] exp_wdata;

  task automatic model_reset();
    stage = M_IDLE; m_len = 0; m_idx = 0; m_x = 8'h00; fill_q.delete();
    exp_ready = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0;
    exp_run = 0; exp_done = 0; exp_err = 0;
  endtask

  task automatic body_complete();
    for (int a = m_len; a < 16; a++) fill_q.push_back(a);
    stage = (fill_q.size() != 0) ? M_FILL : M_RUN;
  endtask

  task automatic model_step();
    bit acc;
    acc = byte_valid && exp_ready;
    exp_we = 1'b0;
    if (load_req) begin
      stage = M_LEN;
      fill_q.delete();
    end else begin
      case (stage)
        M_LEN: if (acc) begin
          if (byte_in >= 8'd1 && byte_in <= 8'd16) begin
            m_len = int'(byte_in); m_idx = 0; m_x = 8'h00; stage = M_DATA;
          end else begin
            stage = M_ERR;
          end
        end
        M_DATA: if (acc) begin
          exp_we = 1'b1; exp_addr = 4'(m_idx); exp_wdata = byte_in;
          m_x = m_x ^ byte_in;
          m_idx++;
          if (m_idx == m_len) begin
            if (CSUM_EN) stage = M_CHK;
            else         body_complete();
          end
        end
        M_CHK: if (acc) begin
          if (byte_in == m_x) body_complete();
          else                stage = M_ERR;
        end
        M_FILL: begin
          exp_we = 1'b1; exp_addr = 4'(fill_q.pop_front()); exp_wdata = 8'h00;
          if (fill_q.size() == 0) stage = M_RUN;
        end
        default: ;
      endcase
    end
    exp_ready = (stage == M_LEN) || (stage == M_DATA) || (stage == M_CHK);
    exp_run   = (stage == M_RUN);
    exp_done  = (stage == M_RUN);
    exp_err   = (stage == M_ERR);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("byte_ready", 32'(byte_ready), 32'(exp_ready));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("cpu_run", 32'(cpu_run), 32'(exp_run));
    chk("done", 32'(done), 32'(exp_done));
    chk("err", 32'(err), 32'(exp_err));
    if (exp_we) begin
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    end
  end

  // RAM image and write count as seen by the CPU side.
  logic [7:0] ram [16];
  int         nwr;
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      ram[mem_addr] = mem_wdata;
      nwr++;
      $display("write addr=%0d data=%02h", mem_addr, mem_wdata);
    end
  end

  task automatic clear_image();
    for (int i = 0; i < 16; i++) ram[i] = 8'hAA;
    nwr = 0;
  endtask

  task automatic step(input logic lr, input logic v, input logic [7:0] b);
    load_req = lr; byte_valid = v; byte_in = b;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) step(1'b0, v, 8'h5A);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 0);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_run"}, 32'(cpu_run), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    logic [7:0] x, b;
    rst_n = 1'b0; load_req = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    model_reset();
    clear_image();
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // IDLE ignores byte_valid; nothing happens without load_req.
    idle(4, 1'b1);
    chk("idle_writes", 32'(nwr), 0);
    $display("txn idle_backpressure writes=%0d", nwr);

    // Full load L=3, then byte_valid held high through FILL and RUN.
    clear_image();
    step(1, 0, 8'h00);
    step(0, 1, 8'd3);
    step(0, 1, 8'h1F); step(0, 1, 8'h90); step(0, 1, 8'h80);
    step(0, 1, 8'h0F);
    idle(20, 1'b1);
    chk("full_ram0", 32'(ram[0]), 32'h1F);
    chk("full_ram1", 32'(ram[1]), 32'h90);
    chk("full_ram2", 32'(ram[2]), 32'h80);
    for (int i = 3; i < 16; i++) chk("full_fill", 32'(ram[i]), 0);
    chk("full_nwr", 32'(nwr), 16);
    chk("full_done", 32'(done), 1);
    chk("full_run", 32'(cpu_run), 1);
    $display("txn full_load writes=%0d done=%0d cpu_run=%0d", nwr, done, cpu_run);

    // Restart from RUN drops cpu_run on the next edge; reload with L=16.
    clear_image();
    step(1, 0, 8'h00);
    chk("restart_run", 32'(cpu_run), 0);
    chk("restart_done", 32'(done), 0);
    step(0, 1, 8'd16);
    x = 8'h00;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 3 + 1);
      x = x ^ b;
      step(0, 1, b);
    end
    step(0, 1, x);
    idle(3, 1'b0);
    for (int i = 0; i < 16; i++) chk("l16_ram", 32'(ram[i]), 32'(i * 3 + 1));
    chk("l16_nwr", 32'(nwr), 16);
    chk("l16_done", 32'(done), 1);
    $display("txn reload_l16 writes=%0d done=%0d", nwr, done);

    // Bad checksum: only the data writes land when the check is present.
    clear_image();
    step(1, 0, 8'h00);
    step(0, 1, 8'd3);
    step(0, 1, 8'h1F); step(0, 1, 8'h90); step(0, 1, 8'h80);
    step(0, 1, 8'h00);
    idle(20, 1'b0);
    chk("badck_err", 32'(err), 32'(CSUM_EN));
    chk("badck_run", 32'(cpu_run), 32'(!CSUM_EN));
    chk("badck_nwr", 32'(nwr), CSUM_EN ? 3 : 16);
    $display("txn bad_checksum writes=%0d err=%0d", nwr, err);

    // Bad lengths 0 and 17.
    clear_image();
    step(1, 0, 8'h00); step(0, 1, 8'd0); idle(3, 1'b1);
    chk("len0_err", 32'(err), 1);
    step(1, 0, 8'h00);
    chk("len0_clear_err", 32'(err), 0);
    step(0, 1, 8'd17); idle(3, 1'b1);
    chk("len17_err", 32'(err), 1);
    chk("badlen_nwr", 32'(nwr), 0);
    $display("txn bad_length writes=%0d err=%0d", nwr, err);

    // load_req with a byte in DATA: byte dropped; then load with gaps in byte_valid.
    step(1, 0, 8'h00);
    step(0, 1, 8'd2);
    step(1, 1, 8'hEE);
    chk("collide_nwr", 32'(nwr), 0);
    step(0, 1, 8'd2);
    step(0, 1, 8'hAB);
    step(0, 0, 8'hFF); step(0, 0, 8'hFF);
    step(0, 1, 8'hCD);
    step(0, 0, 8'hFF);
    step(0, 1, 8'h66);
    idle(20, 1'b0);
    chk("gap_ram0", 32'(ram[0]), 32'hAB);
    chk("gap_ram1", 32'(ram[1]), 32'hCD);
    chk("gap_ram2", 32'(ram[2]), 0);
    chk("gap_nwr", 32'(nwr), 16);
    chk("gap_done", 32'(done), 1);
    $display("txn gaps_after_error writes=%0d done=%0d", nwr, done);

    // Mid-load reset right after the second data byte is accepted.
    step(1, 0, 8'h00);
    step(0, 1, 8'd4);
    step(0, 1, 8'h11);
    step(0, 1, 8'h22);
    chk("pre_reset_we", 32'(mem_we), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    clear_image();
    rst_n = 1'b1;
    idle(5, 1'b1);
    chk("post_reset_nwr", 32'(nwr), 0);
    chk("post_reset_ready", 32'(byte_ready), 0);
    chk("post_reset_done", 32'(done), 0);
    $display("txn mid_load_reset writes=%0d", nwr);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
